// File: rtl/btn_pkg.sv
// btn_pkg: shared definitions for the set-button conditioner.
//   btn_state_t   per-channel FSM encoding (3 bits)
//   DEF_*         default timing constants in 32768 Hz clock cycles
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,   // released, nothing pending
        DEB_P = 3'd1,   // press seen, waiting for it to stay stable
        HELD  = 3'd2,   // accepted press, waiting for first auto-repeat
        RPT   = 3'd3,   // auto-repeating
        DEB_R = 3'd4    // release seen, waiting for it to stay stable
    } btn_state_t;

    localparam int unsigned DEF_DEB_CYC     = 655;    // ~20 ms
    localparam int unsigned DEF_RPT_DELAY   = 32768;  // 1 s
    localparam int unsigned DEF_RPT_PERIOD  = 16384;  // 0.5 s
    localparam int unsigned DEF_STRETCH_CYC = 16384;  // one core tick
    localparam int unsigned DEF_CNT_W       = 16;

endpackage

// File: rtl/btn_channel.sv
// btn_channel: one button channel -- synchroniser, debounce/auto-repeat FSM,
// step pulse stretcher.
//   clk, rst_n   system clock, async active-low reset
//   btn_raw_n    raw active-low button, asynchronous to clk
//   rpt_en       auto-repeat enable for this channel
//   btn_level    debounced level, 1 = pressed
//   btn_press    one-clk pulse on accepted press
//   btn_step     stretched pulse, STRETCH_CYC clks per press/repeat
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEB_CYC     = DEF_DEB_CYC,
    parameter int unsigned RPT_DELAY   = DEF_RPT_DELAY,
    parameter int unsigned RPT_PERIOD  = DEF_RPT_PERIOD,
    parameter int unsigned STRETCH_CYC = DEF_STRETCH_CYC,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_n,
    input  logic rpt_en,
    output logic btn_level,
    output logic btn_press,
    output logic btn_step
);

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_MAX = CNT_W'(RPT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_MAX = CNT_W'(RPT_PERIOD - 1);
    localparam logic [CNT_W-1:0] STR_MAX = CNT_W'(STRETCH_CYC - 1);

    logic [1:0]       sync;      // sync[1] is the metastability-safe copy
    logic             pressed;
    btn_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] scnt, scnt_nxt;
    logic             was_rpt, was_rpt_nxt;  // where DEB_R returns on a bounce
    logic             level_nxt, press_nxt, step_nxt;
    logic             fire;

    // Flops reset to 1 so a held button after reset still reads "released"
    // first and has to debounce from scratch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], btn_raw_n};
    end

    assign pressed = ~sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            scnt      <= '0;
            was_rpt   <= 1'b0;
            btn_level <= 1'b0;
            btn_press <= 1'b0;
            btn_step  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            scnt      <= scnt_nxt;
            was_rpt   <= was_rpt_nxt;
            btn_level <= level_nxt;
            btn_press <= press_nxt;
            btn_step  <= step_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        was_rpt_nxt = was_rpt;
        level_nxt   = btn_level;
        press_nxt   = 1'b0;
        fire        = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (pressed) state_nxt = DEB_P;
            end
            DEB_P: begin
                if (!pressed) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_MAX) begin
                    state_nxt   = HELD;
                    level_nxt   = 1'b1;
                    press_nxt   = 1'b1;
                    fire        = 1'b1;
                    was_rpt_nxt = 1'b0;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_nxt   = DEB_R;
                    was_rpt_nxt = 1'b0;
                    cnt_nxt     = '0;
                end else if (!rpt_en) begin
                    // Parked at 0 so the count never runs past its compare.
                    cnt_nxt = '0;
                end else if (cnt == DLY_MAX) begin
                    state_nxt = RPT;
                    fire      = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RPT: begin
                if (!pressed) begin
                    state_nxt   = DEB_R;
                    was_rpt_nxt = 1'b1;
                    cnt_nxt     = '0;
                end else if (!rpt_en) begin
                    // Repeat switched off mid-hold: stay here, emit nothing.
                    cnt_nxt = '0;
                end else if (cnt == PER_MAX) begin
                    fire    = 1'b1;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DEB_R: begin
                if (pressed) begin
                    state_nxt = was_rpt ? RPT : HELD;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_MAX) begin
                    state_nxt = IDLE;
                    level_nxt = 1'b0;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Stretcher: a fire reloads even while high, merging into one long pulse.
    always_comb begin
        scnt_nxt = scnt;
        step_nxt = btn_step;
        if (fire) begin
            scnt_nxt = STR_MAX;
            step_nxt = 1'b1;
        end else if (scnt != '0) begin
            scnt_nxt = scnt - CNT_W'(1);
        end else begin
            step_nxt = 1'b0;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: front end for the clock's set buttons (HH, MM, SS, SAFE).
// One independent btn_channel per button, no cross-channel priority.
//   clk, rst_n   system clock (32768 Hz), async active-low reset
//   btn_raw_n    raw active-low buttons
//   rpt_en       per-channel auto-repeat enable
//   btn_level    debounced levels, 1 = pressed
//   btn_press    one-clk press pulses
//   btn_step     stretched steps for the core's tick sampler
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN       = 4,
    parameter int unsigned DEB_CYC     = DEF_DEB_CYC,
    parameter int unsigned RPT_DELAY   = DEF_RPT_DELAY,
    parameter int unsigned RPT_PERIOD  = DEF_RPT_PERIOD,
    parameter int unsigned STRETCH_CYC = DEF_STRETCH_CYC,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw_n,
    input  logic [N_BTN-1:0] rpt_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_step
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEB_CYC    (DEB_CYC),
            .RPT_DELAY  (RPT_DELAY),
            .RPT_PERIOD (RPT_PERIOD),
            .STRETCH_CYC(STRETCH_CYC),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_raw_n(btn_raw_n[i]),
            .rpt_en   (rpt_en[i]),
            .btn_level(btn_level[i]),
            .btn_press(btn_press[i]),
            .btn_step (btn_step[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: small timing constants on the main instance,
// checked every cycle against a timing-rule model; a second instance with
// the default timing ratios (scaled by 1/512) driven through a core-tick
// sampler.
module tb_btn_conditioner;

    localparam int NB = 4;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int SC = 8;

    // default ratios scaled: 1 s = 64 clk, core tick = 32 clk
    localparam int CD   = 5;
    localparam int CRD  = 64;
    localparam int CRP  = 32;
    localparam int CSC  = 32;
    localparam int TICK = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] raw_n = '1;
    logic [NB-1:0] rpt_en = '0;
    logic [NB-1:0] btn_level, btn_press, btn_step;

    logic [0:0] raw2_n = 1'b1;
    logic [0:0] rpt2 = 1'b0;
    logic [0:0] level2, press2, step2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    btn_conditioner #(.N_BTN(NB), .DEB_CYC(D), .RPT_DELAY(RD), .RPT_PERIOD(RP),
                      .STRETCH_CYC(SC), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw_n(raw_n), .rpt_en(rpt_en),
        .btn_level(btn_level), .btn_press(btn_press), .btn_step(btn_step));

    btn_conditioner #(.N_BTN(1), .DEB_CYC(CD), .RPT_DELAY(CRD), .RPT_PERIOD(CRP),
                      .STRETCH_CYC(CSC), .CNT_W(16)) dut_core (
        .clk(clk), .rst_n(rst_n), .btn_raw_n(raw2_n), .rpt_en(rpt2),
        .btn_level(level2), .btn_press(press2), .btn_step(step2));

    // ---------------- reference model ----------------
    // Rules: the raw pin is seen two edges late; the level flips once D+1
    // consecutive samples disagree with it; a held press emits a step after
    // RD stable held samples and every RP after that (restarting on any
    // release bounce); each step keeps the output high for SC cycles.
    logic [NB-1:0] m_seen1, m_seen2;
    logic [NB-1:0] m_lvl, m_press, m_step, m_rpt;
    int            m_run[NB], m_hold[NB], m_left[NB];

    task automatic model_reset();
        m_seen1 = '1; m_seen2 = '1;
        m_lvl = '0; m_press = '0; m_step = '0; m_rpt = '0;
        for (int i = 0; i < NB; i++) begin
            m_run[i] = 0; m_hold[i] = 0; m_left[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < NB; i++) begin
            bit p, f;
            p = !m_seen2[i];
            m_seen2[i] = m_seen1[i];
            m_seen1[i] = raw_n[i];
            m_press[i] = 1'b0;
            f = 1'b0;
            if (p != m_lvl[i]) begin
                m_run[i]++;
                m_hold[i] = 0;
                if (m_run[i] == D + 1) begin
                    m_run[i] = 0;
                    m_lvl[i] = p;
                    if (p) begin
                        m_press[i] = 1'b1; f = 1'b1; m_rpt[i] = 1'b0;
                    end
                end
            end else if (!m_lvl[i]) begin
                m_run[i] = 0;
            end else if (m_run[i] > 0) begin
                m_run[i] = 0;           // bounce back: hold timing restarts
                m_hold[i] = 0;
            end else if (!rpt_en[i]) begin
                m_hold[i] = 0;
            end else if (m_hold[i] == (m_rpt[i] ? RP : RD) - 1) begin
                f = 1'b1; m_rpt[i] = 1'b1; m_hold[i] = 0;
            end else begin
                m_hold[i]++;
            end
            if (f) m_left[i] = SC;
            else if (m_left[i] > 0) m_left[i]--;
            m_step[i] = (m_left[i] > 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        cyc++;
        #1;
    endtask

    task automatic settle();
        raw_n = '1; rpt_en = '0;
        repeat (30) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        model_reset();
        #3;
        n_tests++;
        if ({btn_level, btn_press, btn_step} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h want 0", {btn_level, btn_press, btn_step});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            n_tests++;
            if ({btn_level, btn_press, btn_step} !== {m_lvl, m_press, m_step}) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d got %h want %h", cyc,
                         {btn_level, btn_press, btn_step}, {m_lvl, m_press, m_step});
            end
        end
    endtask

    task automatic test_clean_press();
        int lat = -1, npress = 0, nstep = 0;
        raw_n[0] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_tests++;
            if ({btn_level, btn_press, btn_step} !== {m_lvl, m_press, m_step}) begin
                n_fail++;
                $display("FAIL clean_model cyc %0d got %h want %h", cyc,
                         {btn_level, btn_press, btn_step}, {m_lvl, m_press, m_step});
            end
            if (btn_press[0]) begin
                npress++;
                if (lat < 0) lat = k;
            end
            if (btn_step[0]) nstep++;
        end
        n_tests += 4;
        if (lat !== D + 3) begin n_fail++; $display("FAIL clean_latency got %0d want %0d", lat, D + 3); end
        if (npress !== 1)  begin n_fail++; $display("FAIL clean_press_count got %0d want 1", npress); end
        if (nstep !== SC)  begin n_fail++; $display("FAIL clean_step_len got %0d want %0d", nstep, SC); end
        if (btn_level[0] !== 1'b1) begin n_fail++; $display("FAIL clean_level got %b want 1", btn_level[0]); end
        settle();
    endtask

    task automatic test_bounce();
        repeat (5) begin
            for (int k = 0; k < 6; k++) begin
                raw_n[0] = (k >= 3);
                tick();
                n_tests++;
                if ({btn_level, btn_press, btn_step} !== '0 ||
                    {btn_level, btn_press, btn_step} !== {m_lvl, m_press, m_step}) begin
                    n_fail++;
                    $display("FAIL bounce cyc %0d got %h want 0", cyc, {btn_level, btn_press, btn_step});
                end
            end
        end
        settle();
    endtask

    task automatic run_repeat(input bit en, output int rise_off, output int nrise);
        int t0 = -1;
        bit prev = 1'b0;
        rise_off = -1; nrise = 0;
        raw_n[1] = 1'b0; rpt_en[1] = en;
        for (int k = 1; k <= 60; k++) begin
            tick();
            n_tests++;
            if ({btn_level, btn_press, btn_step} !== {m_lvl, m_press, m_step}) begin
                n_fail++;
                $display("FAIL repeat_model en %0b cyc %0d got %h want %h", en, cyc,
                         {btn_level, btn_press, btn_step}, {m_lvl, m_press, m_step});
            end
            if (btn_press[1] && t0 < 0) t0 = k;
            if (btn_step[1] && !prev) begin
                nrise++;
                if (nrise == 2 && t0 >= 0) rise_off = k - t0;
            end
            prev = btn_step[1];
        end
        settle();
    endtask

    task automatic test_auto_repeat();
        int off, nr;
        run_repeat(1'b1, off, nr);
        n_tests++;
        if (off !== RD) begin n_fail++; $display("FAIL repeat_first_offset got %0d want %0d", off, RD); end
        run_repeat(1'b0, off, nr);
        n_tests++;
        if (nr !== 1) begin n_fail++; $display("FAIL norepeat_pulses got %0d want 1", nr); end
    endtask

    task automatic test_release_bounce();
        int lat = -1;
        raw_n[2] = 1'b0;
        repeat (15) tick();
        for (int k = 0; k < 14; k++) begin
            raw_n[2] = (k < 2);
            tick();
            n_tests++;
            if (btn_level[2] !== 1'b1 || btn_press[2] !== 1'b0 ||
                {btn_level, btn_press, btn_step} !== {m_lvl, m_press, m_step}) begin
                n_fail++;
                $display("FAIL release_glitch cyc %0d got lvl %b press %b want 1 0", cyc,
                         btn_level[2], btn_press[2]);
            end
        end
        raw_n[2] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (!btn_level[2] && lat < 0) lat = k;
        end
        n_tests++;
        if (lat !== D + 3) begin n_fail++; $display("FAIL release_latency got %0d want %0d", lat, D + 3); end
        settle();
    endtask

    task automatic test_reset_mid_stretch();
        int lat = -1;
        raw_n[0] = 1'b0;
        repeat (D + 5) tick();
        n_tests++;
        if (btn_step[0] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_step got %b want 1", btn_step[0]); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({btn_level, btn_press, btn_step, level2, press2, step2} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got %h want 0", {btn_level, btn_press, btn_step});
        end
        repeat (3) tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            n_tests++;
            if ({btn_level, btn_press, btn_step} !== {m_lvl, m_press, m_step}) begin
                n_fail++;
                $display("FAIL post_reset_model cyc %0d got %h want %h", cyc,
                         {btn_level, btn_press, btn_step}, {m_lvl, m_press, m_step});
            end
            if (btn_press[0] && lat < 0) lat = k;
        end
        n_tests++;
        if (lat !== D + 3) begin n_fail++; $display("FAIL post_reset_latency got %0d want %0d", lat, D + 3); end
        settle();
    endtask

    task automatic test_random();
        for (int s = 0; s < 60; s++) begin
            int len;
            raw_n  = NB'($urandom);
            rpt_en = NB'($urandom);
            len = $urandom_range(1, 25);
            repeat (len) begin
                tick();
                n_tests++;
                if ({btn_level, btn_press, btn_step} !== {m_lvl, m_press, m_step}) begin
                    n_fail++;
                    $display("FAIL random cyc %0d got %h want %h", cyc,
                             {btn_level, btn_press, btn_step}, {m_lvl, m_press, m_step});
                end
            end
        end
        settle();
    endtask

    // Core samples btn_step on every TICK-th clock; count increments it sees.
    task automatic core_run(input int hold, input int total, output int incs);
        incs = 0;
        raw2_n = 1'b0; rpt2 = 1'b1;
        for (int k = 0; k < total; k++) begin
            if (k == hold) raw2_n = 1'b1;
            tick();
            if ((cyc % TICK) == 0 && step2[0]) incs++;
        end
        rpt2 = 1'b0;
    endtask

    task automatic test_core_tick();
        int incs;
        core_run(20, 200, incs);
        n_tests++;
        if (incs !== 1) begin n_fail++; $display("FAIL core_single_press got %0d want 1", incs); end
        core_run(3 * CRD, 3 * CRD + 100, incs);
        n_tests++;
        if (incs !== 5) begin n_fail++; $display("FAIL core_3s_hold got %0d want 5", incs); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_release_bounce();
        test_reset_mid_stretch();
        test_random();
        test_core_tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
